stereolbm_axis_cambm_mul_pipe: RTL and testbench

STEREOLBM_AXIS_CAMBM_MUL_PIPE -- requirements
Module: stereolbm_axis_cambm_mul_pipe

---
 rtl/stereolbm_axis_cambm_mul_pipe.sv | 191 +++++++++++++++++++
 tb/tb_stereolbm_axis_cambm_mul_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stereolbm_axis_cambm_mul_pipe.sv
// Pipelined scaled multiplier with optional round-half-up, right shift and
// saturation, carrying a valid bit alongside every stage.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-high reset, overrides ce
//   ce         - pipeline advance enable; all registers hold when low
//   din_valid  - din0/din1 carry an operand pair
//   din0/din1  - operands, each signed or unsigned per SIGNED0/SIGNED1
//   dout_valid - dout carries a result (final-stage valid bit)
//   dout       - scaled product, registered
//   ovf        - dout differs from the scaled product (clamped or wrapped)
module stereolbm_axis_cambm_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_valid,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int unsigned PW      = din0_WIDTH + din1_WIDTH;
  localparam int unsigned QW      = PW + 1;
  localparam int unsigned DW      = dout_WIDTH;
  localparam int unsigned SH      = SHIFT;
  localparam bit          SGN     = (SIGNED0 != 0) || (SIGNED1 != 0);
  localparam bit          DO_RND  = (ROUND != 0) && (SHIFT > 0);
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [QW-1:0] RND   = DO_RND ? (QW'(1) << RND_POS) : '0;
  localparam logic [DW-1:0] S_MIN = DW'(1) << (DW - 1);
  localparam logic [DW-1:0] S_MAX = ~S_MIN;
  localparam logic [DW-1:0] U_MAX = '1;
  localparam bit          SAT     = (SATURATE != 0);

  // Instance tag only; no hardware depends on it.
  if (ID < 0) begin : g_id_tag
  end

  // Operand extension and full-width product.
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod_c;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    if (SIGNED0 != 0) a_ext = PW'($signed(din0));
    else              a_ext = PW'(din0);
    if (SIGNED1 != 0) b_ext = PW'($signed(din1));
    else              b_ext = PW'(din1);
    // Low PW bits of the extended product are exact for every sign mix.
    prod_c = PW'(a_ext * b_ext);
  end

  // Product pipeline feeding the final scaling stage.
  logic [PW-1:0] p_fin;
  logic          v_fin;

  if (NUM_STAGE == 1) begin : g_single
    // Single stage: scaling works directly on the input product.
    assign p_fin = prod_c;
    assign v_fin = din_valid;
  end else begin : g_pipe
    localparam int unsigned NP = NUM_STAGE - 1;

    logic [PW-1:0] p_q [NP];
    logic [PW-1:0] p_d [NP];
    logic [NP-1:0] v_q;
    logic [NP-1:0] v_d;

    // Shift chain: stage 0 is the product register.
    always_comb begin
      for (int i = 0; i < NP; i++) begin
        p_d[i] = '0;
      end
      v_d    = '0;
      p_d[0] = prod_c;
      v_d[0] = din_valid;
      for (int i = 1; i < NP; i++) begin
        p_d[i] = p_q[i-1];
        v_d[i] = v_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < NP; i++) begin
          p_q[i] <= '0;
        end
        v_q <= '0;
      end else if (ce) begin
        for (int i = 0; i < NP; i++) begin
          p_q[i] <= p_d[i];
        end
        v_q <= v_d;
      end
    end

    assign p_fin = p_q[NP-1];
    assign v_fin = v_q[NP-1];
  end

  // Round, shift and range-fit of the product.
  logic [QW-1:0] p_ext;
  logic [QW-1:0] sum;
  logic [QW-1:0] q;
  logic [QW-1:0] hi;
  logic          fit;
  logic          neg;
  logic [DW-1:0] dout_d;
  logic          ovf_d;

  always_comb begin
    p_ext  = '0;
    sum    = '0;
    q      = '0;
    hi     = '0;
    fit    = 1'b1;
    neg    = 1'b0;
    dout_d = '0;
    ovf_d  = 1'b0;

    if (SGN) p_ext = QW'($signed(p_fin));
    else     p_ext = QW'(p_fin);

    // One extra bit of headroom so the rounding add cannot overflow.
    sum = p_ext + RND;

    if (SGN) q = QW'($signed(sum) >>> SH);
    else     q = sum >> SH;

    // Q fits when every bit above the dout range matches the sign (signed)
    // or is zero (unsigned).
    if (SGN) begin
      hi  = QW'($signed(q) >>> (DW - 1));
      fit = (hi == '0) || (hi == '1);
      neg = q[QW-1];
    end else begin
      fit = ((q >> DW) == '0);
    end

    if (fit) begin
      dout_d = DW'(q);
      ovf_d  = 1'b0;
    end else if (SAT) begin
      // Unsigned Q is never negative, so it can only exceed the maximum.
      if (SGN) dout_d = neg ? S_MIN : S_MAX;
      else     dout_d = U_MAX;
      ovf_d  = 1'b1;
    end else begin
      dout_d = DW'(q);
      ovf_d  = 1'b1;
    end
  end

  // Final registered stage.
  logic [DW-1:0] dout_q;
  logic          ovf_q;
  logic          dout_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q       <= '0;
      ovf_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else if (ce) begin
      dout_q       <= dout_d;
      ovf_q        <= ovf_d;
      dout_valid_q <= v_fin;
    end
  end

  assign dout       = dout_q;
  assign ovf        = ovf_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_stereolbm_axis_cambm_mul_pipe.sv
// Bench for the scaled multiplier: a signed round/saturate instance and an
// unsigned wrap instance share stimulus; both have a three-stage pipeline.
module tb_stereolbm_axis_cambm_mul_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       din_valid;
  logic [7:0] din0;
  logic [7:0] din1;

  logic       dv_s, ovf_s;
  logic [7:0] dout_s;
  logic       dv_u, ovf_u;
  logic [7:0] dout_u;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stereolbm_axis_cambm_mul_pipe #(
    .ID(1), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .SIGNED0(1), .SIGNED1(1), .SHIFT(4), .ROUND(1), .SATURATE(1)
  ) dut_s (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1),
    .dout_valid(dv_s), .dout(dout_s), .ovf(ovf_s)
  );

  stereolbm_axis_cambm_mul_pipe #(
    .ID(2), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .SIGNED0(0), .SIGNED1(0), .SHIFT(4), .ROUND(0), .SATURATE(0)
  ) dut_u (
    .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1),
    .dout_valid(dv_u), .dout(dout_u), .ovf(ovf_u)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s_dout;
    logic       s_ovf;
    logic [7:0] u_dout;
    logic       u_ovf;
  } vec_t;

  typedef struct {
    logic       v;
    logic [7:0] sd;
    logic       so;
    logic [7:0] ud;
    logic       uo;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v);
    din0      = a;
    din1      = b;
    din_valid = v;
  endtask

  // Reference: exact integer product, optional round-half-up, floor shift,
  // then clamp or wrap to 8 bits.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                input bit sgn, input bit rnd, input bit sat,
                                output logic [7:0] d, output logic o);
    longint av, bv, p, q, lo, hi;
    av = sgn ? longint'($signed(a)) : longint'(a);
    bv = sgn ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    if (rnd) p = p + 8;
    q  = p >>> 4;
    lo = sgn ? -128 : 0;
    hi = sgn ? 127 : 255;
    if (q > hi) begin
      o = 1'b1;
      d = sat ? 8'(hi) : 8'(q);
    end else if (q < lo) begin
      o = 1'b1;
      d = sat ? 8'(lo) : 8'(q);
    end else begin
      o = 1'b0;
      d = 8'(q);
    end
  endfunction

  vec_t vecs [12];
  exp_t hist [$];

  initial begin
    vecs[0]  = '{8'h03, 8'h08, 8'h02, 1'b0, 8'h01, 1'b0};
    vecs[1]  = '{8'hFD, 8'h08, 8'hFF, 1'b0, 8'h7E, 1'b0};
    vecs[2]  = '{8'h80, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
    vecs[3]  = '{8'h80, 8'h7F, 8'h80, 1'b1, 8'hF8, 1'b1};
    vecs[4]  = '{8'hFF, 8'hFF, 8'h00, 1'b0, 8'hE0, 1'b1};
    vecs[5]  = '{8'h01, 8'h07, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{8'h01, 8'h08, 8'h01, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{8'hFF, 8'h09, 8'hFF, 1'b0, 8'h8F, 1'b0};
    vecs[8]  = '{8'h7F, 8'h7F, 8'h7F, 1'b1, 8'hF0, 1'b1};
    vecs[9]  = '{8'h10, 8'h08, 8'h08, 1'b0, 8'h08, 1'b0};
    vecs[10] = '{8'hF8, 8'h02, 8'hFF, 1'b0, 8'h1F, 1'b0};
    vecs[11] = '{8'h40, 8'h40, 8'h7F, 1'b1, 8'h00, 1'b1};

    // Reset with ce low: reset must still clear the outputs.
    reset = 1'b1;
    ce    = 1'b0;
    drive(8'h00, 8'h00, 1'b0);
    step();
    step();
    check("rst_dv_s",   32'(dv_s),   32'(0));
    check("rst_dout_s", 32'(dout_s), 32'(0));
    check("rst_ovf_s",  32'(ovf_s),  32'(0));
    check("rst_dv_u",   32'(dv_u),   32'(0));
    check("rst_dout_u", 32'(dout_u), 32'(0));
    check("rst_ovf_u",  32'(ovf_u),  32'(0));
    reset = 1'b0;
    ce    = 1'b1;

    // Directed vectors, one at a time, checking the three-edge latency.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a, vecs[i].b, 1'b1);
      step();
      drive(8'h00, 8'h00, 1'b0);
      check($sformatf("vec%0d_dv_e1", i), 32'(dv_s), 32'(0));
      step();
      check($sformatf("vec%0d_dv_e2", i), 32'(dv_s), 32'(0));
      step();
      check($sformatf("vec%0d_dv_s", i),   32'(dv_s),   32'(1));
      check($sformatf("vec%0d_dout_s", i), 32'(dout_s), 32'(vecs[i].s_dout));
      check($sformatf("vec%0d_ovf_s", i),  32'(ovf_s),  32'(vecs[i].s_ovf));
      check($sformatf("vec%0d_dv_u", i),   32'(dv_u),   32'(1));
      check($sformatf("vec%0d_dout_u", i), 32'(dout_u), 32'(vecs[i].u_dout));
      check($sformatf("vec%0d_ovf_u", i),  32'(ovf_u),  32'(vecs[i].u_ovf));
    end

    // Stall: 7*5 issued, ce low for five cycles with noisy inputs.
    drive(8'h00, 8'h00, 1'b0);
    step(); step(); step();
    drive(8'h07, 8'h05, 1'b1);
    step();
    drive(8'h64, 8'h64, 1'b1);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d_dv", i),   32'(dv_s),   32'(0));
      check($sformatf("stall%0d_dout", i), 32'(dout_s), 32'(0));
      check($sformatf("stall%0d_ovf", i),  32'(ovf_s),  32'(0));
    end
    ce = 1'b1;
    drive(8'h00, 8'h00, 1'b0);
    step();
    check("stall_resume_dv", 32'(dv_s), 32'(0));
    step();
    check("stall_out_dv",   32'(dv_s),   32'(1));
    check("stall_out_dout", 32'(dout_s), 32'(2));
    check("stall_out_ovf",  32'(ovf_s),  32'(0));
    check("stall_out_dv_u", 32'(dv_u),   32'(1));
    check("stall_out_dout_u", 32'(dout_u), 32'(2));

    // Reset with three valid pairs in flight (third presented at reset edge).
    drive(8'h00, 8'h00, 1'b0);
    step(); step(); step();
    drive(8'h80, 8'h80, 1'b1);
    step();
    drive(8'h7F, 8'h7F, 1'b1);
    step();
    check("pre_rst_dv", 32'(dv_s), 32'(0));
    drive(8'h80, 8'h7F, 1'b1);
    reset = 1'b1;
    ce    = 1'b0;
    step();
    reset = 1'b0;
    ce    = 1'b1;
    check("mid_rst_dv_s",   32'(dv_s),   32'(0));
    check("mid_rst_dout_s", 32'(dout_s), 32'(0));
    check("mid_rst_ovf_s",  32'(ovf_s),  32'(0));
    check("mid_rst_dv_u",   32'(dv_u),   32'(0));
    check("mid_rst_dout_u", 32'(dout_u), 32'(0));
    check("mid_rst_ovf_u",  32'(ovf_u),  32'(0));
    drive(8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_rst%0d_dv_s", i), 32'(dv_s), 32'(0));
      check($sformatf("post_rst%0d_dv_u", i), 32'(dv_u), 32'(0));
    end

    // Streaming: back-to-back random pairs with random valid.
    for (int i = 0; i < 103; i++) begin
      logic [7:0] a, b;
      logic       v;
      exp_t       e;
      if (i < 100) begin
        a = 8'($urandom);
        b = 8'($urandom);
        v = 1'($urandom_range(0, 1));
      end else begin
        a = 8'h00;
        b = 8'h00;
        v = 1'b0;
      end
      drive(a, b, v);
      e.v = v;
      model(a, b, 1'b1, 1'b1, 1'b1, e.sd, e.so);
      model(a, b, 1'b0, 1'b0, 1'b0, e.ud, e.uo);
      hist.push_back(e);
      step();
      if (i >= 2) begin
        e = hist.pop_front();
        check($sformatf("strm%0d_dv_s", i - 2),   32'(dv_s),   32'(e.v));
        check($sformatf("strm%0d_dout_s", i - 2), 32'(dout_s), 32'(e.sd));
        check($sformatf("strm%0d_ovf_s", i - 2),  32'(ovf_s),  32'(e.so));
        check($sformatf("strm%0d_dv_u", i - 2),   32'(dv_u),   32'(e.v));
        check($sformatf("strm%0d_dout_u", i - 2), 32'(dout_u), 32'(e.ud));
        check($sformatf("strm%0d_ovf_u", i - 2),  32'(ovf_u),  32'(e.uo));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
